// File: rtl/filter_buf_pkg.sv
// Shared defaults and FSM state encoding for the filter coefficient buffer bank.
package filter_buf_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int K_MAX_DEF  = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } fsm_state_e;

endpackage

// File: rtl/filter_slot.sv
// One K_MAX x K_MAX coefficient slot: whole-slot clear, single element write,
// all elements presented in parallel (element i at bits [i*DATA_W +: DATA_W]).
module filter_slot
   import filter_buf_pkg::*;
#(
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  K_MAX  = K_MAX_DEF,
   localparam int NE     = K_MAX * K_MAX,
   localparam int IDX_W  = $clog2(NE)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     wr_idx,
   input  logic [DATA_W-1:0]    wr_data,
   output logic [NE*DATA_W-1:0] elems
);

   logic [DATA_W-1:0] elem_q [NE];

   // Element storage: clear wins, otherwise write the addressed element.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NE; i++) elem_q[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < NE; i++) elem_q[i] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NE; i++) begin
            if (wr_idx == IDX_W'(i)) elem_q[i] <= wr_data;
         end
      end
   end

   for (genvar g = 0; g < NE; g++) begin : g_out
      assign elems[g*DATA_W +: DATA_W] = elem_q[g];
   end

endmodule

// File: rtl/filter_buffer_bank.sv
// Bank of NUM_FILTERS coefficient slots, loaded one beat at a time in row-major
// order and read back as a whole filter one cycle after a read request.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for load_start with a legal slot number
//   ST_LOAD | accepting K*K coefficient beats into the latched slot
//   ST_DONE | one-cycle load_done pulse, slot flagged as loaded
module filter_buffer_bank
   import filter_buf_pkg::*;
#(
   parameter int  DATA_W      = DATA_W_DEF,
   parameter int  K_MAX       = K_MAX_DEF,
   parameter int  NUM_FILTERS = 4,
   localparam int SEL_W       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
   localparam int FW          = K_MAX * K_MAX * DATA_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_start,
   input  logic [SEL_W-1:0]       load_sel,
   input  logic                   k_mode,
   input  logic                   wr_valid,
   input  logic [DATA_W-1:0]      wr_data,
   output logic                   wr_ready,
   output logic                   busy,
   output logic                   load_done,
   output logic [NUM_FILTERS-1:0] filter_loaded,
   input  logic                   rd_en,
   input  logic [SEL_W-1:0]       rd_sel,
   output logic                   rd_valid,
   output logic [FW-1:0]          rd_filter
);

   localparam int NE    = K_MAX * K_MAX;
   localparam int IDX_W = $clog2(NE);
   localparam int RC_W  = $clog2(K_MAX);

   fsm_state_e             state_q, state_d;
   logic [SEL_W-1:0]       slot_q, slot_d;
   logic                   kmode_q, kmode_d;
   logic [IDX_W-1:0]       rem_q, rem_d;
   logic [RC_W-1:0]        row_q, row_d;
   logic [RC_W-1:0]        col_q, col_d;
   logic [NUM_FILTERS-1:0] loaded_q, loaded_d;
   logic                   rd_valid_q, rd_valid_d;
   logic [FW-1:0]          rd_filter_q, rd_filter_d;

   logic                   start_ok;
   logic                   accept;
   int                     k_cur;
   logic [IDX_W-1:0]       wr_idx;
   logic [NUM_FILTERS-1:0] clr_vec;
   logic [NUM_FILTERS-1:0] wr_vec;
   logic [FW-1:0]          slot_data [NUM_FILTERS];

   // Load sequencing: rem_q counts down the beats still owed, row/col track
   // the destination element so no divider is needed.
   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      kmode_d  = kmode_q;
      rem_d    = rem_q;
      row_d    = row_q;
      col_d    = col_q;
      loaded_d = loaded_q;
      start_ok = 1'b0;
      accept   = 1'b0;
      k_cur    = kmode_q ? 3 : K_MAX;
      unique case (state_q)
         ST_IDLE: begin
            if (load_start && (int'(load_sel) < NUM_FILTERS)) begin
               start_ok = 1'b1;
               state_d  = ST_LOAD;
               slot_d   = load_sel;
               kmode_d  = k_mode;
               rem_d    = IDX_W'((k_mode ? 9 : NE) - 1);
               row_d    = '0;
               col_d    = '0;
               for (int i = 0; i < NUM_FILTERS; i++) begin
                  if (load_sel == SEL_W'(i)) loaded_d[i] = 1'b0;
               end
            end
         end
         ST_LOAD: begin
            if (wr_valid) begin
               accept = 1'b1;
               if (rem_q == '0) begin
                  state_d = ST_DONE;
                  for (int i = 0; i < NUM_FILTERS; i++) begin
                     if (slot_q == SEL_W'(i)) loaded_d[i] = 1'b1;
                  end
               end else begin
                  rem_d = rem_q - 1'b1;
                  if (int'(col_q) == k_cur - 1) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Read port: only a loaded, in-range slot produces a valid result;
   // otherwise the previous filter is held.
   always_comb begin
      rd_valid_d  = 1'b0;
      rd_filter_d = rd_filter_q;
      if (rd_en) begin
         for (int i = 0; i < NUM_FILTERS; i++) begin
            if ((rd_sel == SEL_W'(i)) && loaded_q[i]) begin
               rd_valid_d  = 1'b1;
               rd_filter_d = slot_data[i];
            end
         end
      end
   end

   // Control and read-port registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         slot_q      <= '0;
         kmode_q     <= 1'b0;
         rem_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         loaded_q    <= '0;
         rd_valid_q  <= 1'b0;
         rd_filter_q <= '0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         kmode_q     <= kmode_d;
         rem_q       <= rem_d;
         row_q       <= row_d;
         col_q       <= col_d;
         loaded_q    <= loaded_d;
         rd_valid_q  <= rd_valid_d;
         rd_filter_q <= rd_filter_d;
      end
   end

   assign wr_idx = IDX_W'(int'(row_q) * K_MAX + int'(col_q));

   for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_slot
      assign clr_vec[g] = start_ok && (load_sel == SEL_W'(g));
      assign wr_vec[g]  = accept && (slot_q == SEL_W'(g));

      filter_slot #(
         .DATA_W (DATA_W),
         .K_MAX  (K_MAX)
      ) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .clr     (clr_vec[g]),
         .wr_en   (wr_vec[g]),
         .wr_idx  (wr_idx),
         .wr_data (wr_data),
         .elems   (slot_data[g])
      );
   end

   assign wr_ready      = (state_q == ST_LOAD);
   assign busy          = (state_q == ST_LOAD);
   assign load_done     = (state_q == ST_DONE);
   assign filter_loaded = loaded_q;
   assign rd_valid      = rd_valid_q;
   assign rd_filter     = rd_filter_q;

endmodule

// File: tb/tb_filter_buffer_bank.sv
// Directed bench for filter_buffer_bank: default 4 x 5x5 x 16-bit bank, plus a
// 3-slot 3x3 instance used to exercise out-of-range slot numbers.
module tb_filter_buffer_bank;

   logic         clk;
   logic         rst_n;

   logic         load_start, k_mode, wr_valid, rd_en;
   logic [1:0]   load_sel, rd_sel;
   logic [15:0]  wr_data;
   logic         wr_ready, busy, load_done, rd_valid;
   logic [3:0]   filter_loaded;
   logic [399:0] rd_filter;

   logic         b_load_start, b_k_mode, b_wr_valid, b_rd_en;
   logic [1:0]   b_load_sel, b_rd_sel;
   logic [7:0]   b_wr_data;
   logic         b_wr_ready, b_busy, b_load_done, b_rd_valid;
   logic [2:0]   b_filter_loaded;
   logic [71:0]  b_rd_filter;

   int n_checks = 0;
   int n_pass   = 0;

   filter_buffer_bank #(
      .DATA_W      (16),
      .K_MAX       (5),
      .NUM_FILTERS (4)
   ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_start    (load_start),
      .load_sel      (load_sel),
      .k_mode        (k_mode),
      .wr_valid      (wr_valid),
      .wr_data       (wr_data),
      .wr_ready      (wr_ready),
      .busy          (busy),
      .load_done     (load_done),
      .filter_loaded (filter_loaded),
      .rd_en         (rd_en),
      .rd_sel        (rd_sel),
      .rd_valid      (rd_valid),
      .rd_filter     (rd_filter)
   );

   filter_buffer_bank #(
      .DATA_W      (8),
      .K_MAX       (3),
      .NUM_FILTERS (3)
   ) u_dut3 (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_start    (b_load_start),
      .load_sel      (b_load_sel),
      .k_mode        (b_k_mode),
      .wr_valid      (b_wr_valid),
      .wr_data       (b_wr_data),
      .wr_ready      (b_wr_ready),
      .busy          (b_busy),
      .load_done     (b_load_done),
      .filter_loaded (b_filter_loaded),
      .rd_en         (b_rd_en),
      .rd_sel        (b_rd_sel),
      .rd_valid      (b_rd_valid),
      .rd_filter     (b_rd_filter)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] elem(input int r, input int c);
      return rd_filter[(r*5+c)*16 +: 16];
   endfunction

   task automatic read_slot(input int sel);
      rd_en  = 1'b1;
      rd_sel = 2'(sel);
      tick();
      rd_en  = 1'b0;
   endtask

   // Runs one load; lat counts cycles inclusively from the load_start cycle to
   // the load_done cycle. With stress set, slot 3 is read every cycle (slot 1
   // once), and load_start is raised mid-load and in the DONE cycle.
   task automatic load_filter(input int sel, input bit km, input int base, input bit toggle,
                              input bit stress, output int lat, output int busy_cyc,
                              output int pulses);
      int beat;
      bit v;
      beat = 0; v = 1'b1; lat = 0; busy_cyc = 0; pulses = 0;
      load_start = 1'b1; load_sel = 2'(sel); k_mode = km; wr_valid = 1'b0;
      tick();
      load_start = 1'b0;
      for (int c = 1; c < 200; c++) begin
         if (busy) busy_cyc++;
         if (load_done) begin
            pulses++;
            if (lat == 0) lat = c + 1;
         end
         if (lat != 0 && c == lat) begin
            check("idle_after_done", 64'(busy), 64'd0);
            break;
         end
         if (stress) begin
            if (c >= 2) begin
               check("bg_rd_valid", 64'(rd_valid), (c == 6) ? 64'd0 : 64'd1);
               check("bg_rd_e00", 64'(elem(0, 0)), 64'd100);
               check("bg_rd_e44", 64'(elem(4, 4)), 64'd124);
            end
            if (c == 3) check("reload_flag_clr", 64'(filter_loaded), 64'b1101);
            rd_en  = 1'b1;
            rd_sel = (c == 5) ? 2'd1 : 2'd3;
            if (c == 4 || load_done) begin
               load_start = 1'b1; load_sel = 2'd0; k_mode = 1'b1;
            end else begin
               load_start = 1'b0; k_mode = km;
            end
         end
         if (busy) begin
            wr_valid = toggle ? v : 1'b1;
            wr_data  = 16'(base + beat);
            if (wr_valid) beat++;
            v = ~v;
         end else begin
            wr_valid = 1'b0;
         end
         tick();
      end
      load_start = 1'b0; rd_en = 1'b0; wr_valid = 1'b0; k_mode = 1'b0;
   endtask

   initial begin
      int lat, bc, np;
      rst_n = 1'b0;
      load_start = 1'b0; load_sel = '0; k_mode = 1'b0; wr_valid = 1'b0; wr_data = '0;
      rd_en = 1'b0; rd_sel = '0;
      b_load_start = 1'b0; b_load_sel = '0; b_k_mode = 1'b0; b_wr_valid = 1'b0;
      b_wr_data = '0; b_rd_en = 1'b0; b_rd_sel = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_wr_ready", 64'(wr_ready), 64'd0);
      check("rst_load_done", 64'(load_done), 64'd0);
      check("rst_loaded", 64'(filter_loaded), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_filter_zero", 64'(rd_filter == '0), 64'd1);
      check("rst_b_busy", 64'(b_busy), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // 5x5 load of 1..25 into slot 2, no stalls
      load_filter(2, 1'b0, 1, 1'b0, 1'b0, lat, bc, np);
      check("s2_latency", 64'(lat), 64'd27);
      check("s2_busy_cycles", 64'(bc), 64'd25);
      check("s2_done_pulses", 64'(np), 64'd1);
      check("s2_loaded", 64'(filter_loaded), 64'b0100);
      read_slot(2);
      check("s2_rd_valid", 64'(rd_valid), 64'd1);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            check($sformatf("s2_e%0d%0d", r, c), 64'(elem(r, c)), 64'(5*r + c + 1));
      tick();
      check("s2_rd_valid_drop", 64'(rd_valid), 64'd0);

      // 3x3 load of 10..18 into slot 0; outer elements stay zero
      load_filter(0, 1'b1, 10, 1'b0, 1'b0, lat, bc, np);
      check("s0_latency", 64'(lat), 64'd11);
      check("s0_done_pulses", 64'(np), 64'd1);
      check("s0_loaded", 64'(filter_loaded), 64'b0101);
      read_slot(0);
      check("s0_rd_valid", 64'(rd_valid), 64'd1);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            check($sformatf("s0_e%0d%0d", r, c), 64'(elem(r, c)),
                  (r < 3 && c < 3) ? 64'(10 + 3*r + c) : 64'd0);

      // 5x5 load into slot 3 with wr_valid toggling 1,0,1,0...
      load_filter(3, 1'b0, 100, 1'b1, 1'b0, lat, bc, np);
      check("s3_latency", 64'(lat), 64'd51);
      check("s3_busy_cycles", 64'(bc), 64'd49);
      check("s3_done_pulses", 64'(np), 64'd1);
      check("s3_loaded", 64'(filter_loaded), 64'b1101);
      read_slot(3);
      check("s3_rd_valid", 64'(rd_valid), 64'd1);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            check($sformatf("s3_e%0d%0d", r, c), 64'(elem(r, c)), 64'(100 + 5*r + c));

      // first load of slot 1, then reload it under background reads
      load_filter(1, 1'b1, 50, 1'b0, 1'b0, lat, bc, np);
      check("s1_loaded", 64'(filter_loaded), 64'b1111);
      load_filter(1, 1'b0, 200, 1'b0, 1'b1, lat, bc, np);
      check("s1r_latency", 64'(lat), 64'd27);
      check("s1r_done_pulses", 64'(np), 64'd1);
      check("s1r_loaded", 64'(filter_loaded), 64'b1111);
      tick();
      check("s1r_no_restart", 64'(busy), 64'd0);
      read_slot(1);
      check("s1r_rd_valid", 64'(rd_valid), 64'd1);
      for (int i = 0; i < 25; i++)
         check($sformatf("s1r_e%0d", i), 64'(elem(i / 5, i % 5)), 64'(200 + i));
      read_slot(0);
      check("s0_kept_e00", 64'(elem(0, 0)), 64'd10);
      check("s0_kept_e22", 64'(elem(2, 2)), 64'd18);
      check("s0_kept_e03", 64'(elem(0, 3)), 64'd0);

      // out-of-range slot numbers on the 3-slot instance
      b_load_start = 1'b1; b_load_sel = 2'd3;
      tick();
      b_load_start = 1'b0;
      check("oor_busy", 64'(b_busy), 64'd0);
      check("oor_loaded", 64'(b_filter_loaded), 64'd0);
      b_rd_en = 1'b1; b_rd_sel = 2'd3;
      tick();
      b_rd_en = 1'b0;
      check("oor_rd_valid", 64'(b_rd_valid), 64'd0);
      b_load_start = 1'b1; b_load_sel = 2'd2;
      tick();
      b_load_start = 1'b0;
      check("b_busy", 64'(b_busy), 64'd1);
      for (int b = 0; b < 9; b++) begin
         b_wr_valid = 1'b1; b_wr_data = 8'(b + 1);
         tick();
      end
      b_wr_valid = 1'b0;
      check("b_load_done", 64'(b_load_done), 64'd1);
      check("b_loaded", 64'(b_filter_loaded), 64'b100);
      b_rd_en = 1'b1; b_rd_sel = 2'd2;
      tick();
      b_rd_en = 1'b0;
      check("b_rd_valid", 64'(b_rd_valid), 64'd1);
      check("b_rd_e0", 64'(b_rd_filter[7:0]), 64'd1);
      check("b_rd_e8", 64'(b_rd_filter[71:64]), 64'd9);

      // reset in the middle of a load (12 beats accepted)
      load_start = 1'b1; load_sel = 2'd2; k_mode = 1'b0;
      tick();
      load_start = 1'b0;
      for (int b = 0; b < 12; b++) begin
         wr_valid = 1'b1; wr_data = 16'(500 + b);
         tick();
      end
      wr_data = 16'd512;
      check("pre_rst_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_wr_ready", 64'(wr_ready), 64'd0);
      check("mid_rst_loaded", 64'(filter_loaded), 64'd0);
      check("mid_rst_rd_filter_zero", 64'(rd_filter == '0), 64'd1);
      check("mid_rst_b_loaded", 64'(b_filter_loaded), 64'd0);
      wr_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      np = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (load_done) np++;
      end
      check("post_rst_no_done", 64'(np), 64'd0);
      check("post_rst_loaded", 64'(filter_loaded), 64'd0);
      check("post_rst_busy", 64'(busy), 64'd0);
      read_slot(2);
      check("post_rst_rd_valid", 64'(rd_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
